dualport_bram_sync: RTL and testbench
=====================================

# dualport_bram_sync

Parametrised true dual-port synchronous RAM: the next generation of the core's shared instruction/data memory. It adds byte-enable writes, a registered read path of configurable latency with a valid strobe, selectable cross-port read-during-write behaviour, and a sequenced hardware clear after reset. It sits between the instruction-fetch port (A) and the load/store port (B), and a `rvalid` strobe replaces the old combinational read.

## Interface
- `DATA_W`, default 32: word width; must be a multiple of 8; `BE_W = DATA_W/8`.
- `DEPTH`, default `MEM_SIZE_BYTES/4`: words; power of two, ≥ 2.
- `ADDR_W`, default 32: byte-address width.
- `RD_LAT`, default 1: read latency in cycles; legal values 1 or 2.
- `RDW_MODE`, default `RDW_OLD`: behaviour of a cross-port read of a word the other port writes in the same cycle.
- `WW_WINNER`, default `PORT_B`: port that wins, per byte lane, when both ports write the same word in the same cycle.
- `CLEAR_ON_RESET`, default `MEM_RESET_CLEARS`: 1 runs the clear sequence after reset.
- `INIT_FILE`, default `MEM_INIT_FILE`: `$readmemh` image; loaded only at time 0.
- `clk` in, 1: clock.
- `rst_n` in, 1: asynchronous active-low reset.
- `a_mem_req`, `b_mem_req` in, 1: request.
- `a_mem_we`, `b_mem_we` in, 1: 1 = write, 0 = read.
- `a_mem_be`, `b_mem_be` in, BE_W: byte enables; ignored on reads.
- `a_mem_addr`, `b_mem_addr` in, ADDR_W: byte address.
- `a_mem_wdata`, `b_mem_wdata` in, DATA_W: write data.
- `a_mem_ready`, `b_mem_ready` out, 1: request accepted this cycle.
- `a_mem_rvalid`, `b_mem_rvalid` out, 1: read data valid.
- `a_mem_rdata`, `b_mem_rdata` out, DATA_W: read data.
- `init_done` out, 1: clear sequence finished; memory usable.

## Operation
- Word index is `addr[log2(BE_W)+IDX_W-1 : log2(BE_W)]`, with `IDX_W = log2(DEPTH)`.
- Low offset bits are ignored, so accesses are word-aligned. Upper bits are ignored, so addresses alias modulo the memory size.
- Accept: `x_mem_ready = x_mem_req & init_done`. This is combinational; there is no backpressure beyond init.
- A request is processed only in the cycle it is accepted.
- Write: each byte lane `i` with `be[i]=1` is updated at the clock edge; other lanes are unchanged. A write with `be=0` is accepted and is a no-op.
- Read: the word is captured at the accept edge and appears `RD_LAT` edges later with `rvalid=1` for exactly one cycle.
- `rdata` holds its last value while `rvalid=0`. One read per port per cycle; back-to-back reads are fully pipelined.
- Cross-port read-during-write of the same word:
  - `RDW_OLD` returns the pre-write word.
  - `RDW_NEW` returns the old word merged with the written lanes of the other port.
- Write-write collision on the same word, per lane:
  - A lane enabled on both ports takes the `WW_WINNER` data.
  - A lane enabled on one port only takes that port's data.
- Clear FSM, states `CLEAR` and `RUN`:
  - Reset enters `CLEAR` if `CLEAR_ON_RESET`=1, else `RUN`.
  - In `CLEAR`, counter `clr_idx` zeroes words `clr_idx` and `clr_idx+DEPTH/2` each cycle. When `clr_idx = DEPTH/2-1`, the FSM moves to `RUN`.
  - `init_done = (state==RUN)`.
- Reset mid-clear restarts the counter at 0. Reset mid-read flushes the read pipeline; no `rvalid` is produced for pre-reset reads.
- With `CLEAR_ON_RESET`=1 the clear overrides the `INIT_FILE` contents.

## Timing
- Reset values: `rvalid`=0, `rdata`=0, `ready`=0 while `CLEAR`, `clr_idx`=0.
- `init_done` resets to `!CLEAR_ON_RESET`.
- Clear takes exactly DEPTH/2 cycles after `rst_n` deasserts. `init_done` rises on the edge that writes the last pair.
- Read accepted at edge N gives `rvalid`/`rdata` after edge N+`RD_LAT`.
- Written data is visible to a same-port read accepted at edge N+1 or later.
- Written data is visible to a cross-port read accepted at edge N or later when `RDW_NEW`, or at N+1 or later when `RDW_OLD`.

## Structure
- Package `mem_pkg`:
  - `rdw_mode_e` {`RDW_OLD`, `RDW_NEW`}
  - `port_sel_e` {`PORT_A`, `PORT_B`}
  - helper function `be_merge(old, new, be)`
- Sub-module `bram_rd_pipe`, one per port: holds `RD_LAT` stages of valid and data registers, with async reset of valid.
- Top level holds the array, the byte-lane write logic, the collision and RDW logic, and the clear FSM.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, DEPTH=16, and requests held high → `ready`=0 for 8 cycles, then `init_done`=1; reads of all 16 words return 0.
- Write 0xDEADBEEF to A @0x10 with `be`=4'hF, then write 0x000000AA with `be`=4'b0001 → read @0x10 returns 0xDEADBEAA; read @0x50 (DEPTH=16) aliases and returns the same.
- `RD_LAT`=2, read stream on A of addresses 0,4,8 on consecutive cycles → `rvalid` high for 3 consecutive cycles starting 2 edges after the first accept, with data in order.
- Word 0x11111111 at @0x20. A reads @0x20 while B writes 0x22222222 to @0x20 with `be`=4'hF → A returns 0x11111111 (`RDW_OLD`) or 0x22222222 (`RDW_NEW`).
- Both ports write @0x8: A 0xAAAAAAAA with `be`=4'b0011, B 0xBBBBBBBB with `be`=4'b0110, `WW_WINNER`=`PORT_B` → read returns 0x00BBBBAA after clear.
- Assert `rst_n` for 1 cycle midway through clear, and separately one cycle after a read accept → clear restarts and still takes 8 cycles; no `rvalid` appears for the flushed read.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_pkg
// Brief  : Shared types, defaults and byte-lane merge helper for the core memory
// Rev    : 1.0
// ============================================================================
package mem_pkg;

   localparam int    MEM_SIZE_BYTES   = 4096;
   localparam bit    MEM_RESET_CLEARS = 1'b1;
   localparam string MEM_INIT_FILE    = "";

   // be_merge works on the widest supported word; callers cast to and from it
   localparam int BE_MERGE_MAX_W  = 256;
   localparam int BE_MERGE_MAX_BE = BE_MERGE_MAX_W / 8;

   typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;
   typedef enum logic {PORT_A, PORT_B} port_sel_e;
   typedef enum logic [0:0] {ST_CLEAR, ST_RUN} clr_state_e;

   function automatic logic [BE_MERGE_MAX_W-1:0] be_merge(
      input logic [BE_MERGE_MAX_W-1:0]  old_word,
      input logic [BE_MERGE_MAX_W-1:0]  new_word,
      input logic [BE_MERGE_MAX_BE-1:0] be
   );
      logic [BE_MERGE_MAX_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < BE_MERGE_MAX_BE; i++) begin
         if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module : bram_rd_pipe
// Brief  : Capture register plus RD_LAT output stages of valid/data for one port
// Rev    : 1.0
// ============================================================================
module bram_rd_pipe #(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);

   localparam int c_stages = RD_LAT + 1;

   logic [c_stages-1:0] r_vld;
   logic [DATA_W-1:0]   r_dat [c_stages];

   // Data only advances behind a valid, so the output holds between reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int s = 0; s < c_stages; s++) r_dat[s] <= '0;
      end else begin
         r_vld <= {r_vld[c_stages-2:0], rd_en};
         if (rd_en) r_dat[0] <= rd_data;
         for (int s = 1; s < c_stages; s++) begin
            if (r_vld[s-1]) r_dat[s] <= r_dat[s-1];
         end
      end
   end

   assign rvalid = r_vld[c_stages-1];
   assign rdata  = r_dat[c_stages-1];

endmodule
`default_nettype wire

// File: rtl/dualport_bram_sync.sv
`default_nettype none
// ============================================================================
// Module : dualport_bram_sync
// Brief  : True dual-port RAM, byte enables, pipelined reads, post-reset clear
// Rev    : 1.0
// ============================================================================
module dualport_bram_sync
   import mem_pkg::*;
#(
   parameter int        DATA_W         = 32,
   parameter int        DEPTH          = MEM_SIZE_BYTES / 4,
   parameter int        ADDR_W         = 32,
   parameter int        RD_LAT         = 1,
   parameter rdw_mode_e RDW_MODE       = RDW_OLD,
   parameter port_sel_e WW_WINNER      = PORT_B,
   parameter bit        CLEAR_ON_RESET = MEM_RESET_CLEARS,
   parameter string     INIT_FILE      = MEM_INIT_FILE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                a_mem_req,
   input  logic                a_mem_we,
   input  logic [DATA_W/8-1:0] a_mem_be,
   input  logic [ADDR_W-1:0]   a_mem_addr,
   input  logic [DATA_W-1:0]   a_mem_wdata,
   output logic                a_mem_ready,
   output logic                a_mem_rvalid,
   output logic [DATA_W-1:0]   a_mem_rdata,
   input  logic                b_mem_req,
   input  logic                b_mem_we,
   input  logic [DATA_W/8-1:0] b_mem_be,
   input  logic [ADDR_W-1:0]   b_mem_addr,
   input  logic [DATA_W-1:0]   b_mem_wdata,
   output logic                b_mem_ready,
   output logic                b_mem_rvalid,
   output logic [DATA_W-1:0]   b_mem_rdata,
   output logic                init_done
);

   localparam int c_be_w   = DATA_W / 8;
   localparam int c_off_w  = $clog2(c_be_w);
   localparam int c_idx_w  = $clog2(DEPTH);
   localparam int c_clr_w  = (c_idx_w > 1) ? c_idx_w - 1 : 1;
   localparam int c_half   = DEPTH / 2;
   localparam bit c_b_wins = (WW_WINNER == PORT_B);

   function automatic logic [DATA_W-1:0] lane_merge(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [c_be_w-1:0] be
   );
      return DATA_W'(be_merge(BE_MERGE_MAX_W'(old_word), BE_MERGE_MAX_W'(new_word),
                              BE_MERGE_MAX_BE'(be)));
   endfunction

   logic [DATA_W-1:0]  r_mem [DEPTH];
   clr_state_e         r_state;
   logic [c_clr_w-1:0] r_clr_idx;
   logic               w_init_done;
   logic [c_idx_w-1:0] w_a_idx, w_b_idx, w_clr_lo, w_clr_hi;
   logic               w_a_wr, w_a_rd, w_b_wr, w_b_rd;
   logic [DATA_W-1:0]  w_a_old, w_b_old, w_a_rd_word, w_b_rd_word;
   logic               w_lose_wr, w_win_wr;
   logic [c_idx_w-1:0] w_lose_idx, w_win_idx;
   logic [c_be_w-1:0]  w_lose_be, w_win_be;
   logic [DATA_W-1:0]  w_lose_wdata, w_win_wdata;
   logic               w_unused;

   // Offset and upper address bits are intentionally dropped (aligned, aliasing)
   assign w_unused = ^{a_mem_addr, b_mem_addr};
   assign w_a_idx  = a_mem_addr[c_off_w+c_idx_w-1:c_off_w];
   assign w_b_idx  = b_mem_addr[c_off_w+c_idx_w-1:c_off_w];

   assign w_init_done = (r_state == ST_RUN);
   assign init_done   = w_init_done;
   assign a_mem_ready = a_mem_req & w_init_done;
   assign b_mem_ready = b_mem_req & w_init_done;
   assign w_a_wr      = a_mem_ready & a_mem_we;
   assign w_a_rd      = a_mem_ready & ~a_mem_we;
   assign w_b_wr      = b_mem_ready & b_mem_we;
   assign w_b_rd      = b_mem_ready & ~b_mem_we;

   assign w_a_old = r_mem[w_a_idx];
   assign w_b_old = r_mem[w_b_idx];
   assign w_a_rd_word = (RDW_MODE == RDW_NEW && w_b_wr && (w_b_idx == w_a_idx))
                        ? lane_merge(w_a_old, b_mem_wdata, b_mem_be) : w_a_old;
   assign w_b_rd_word = (RDW_MODE == RDW_NEW && w_a_wr && (w_a_idx == w_b_idx))
                        ? lane_merge(w_b_old, a_mem_wdata, a_mem_be) : w_b_old;

   // The winning port is applied last so its lanes override on a collision
   assign w_lose_wr    = c_b_wins ? w_a_wr      : w_b_wr;
   assign w_lose_idx   = c_b_wins ? w_a_idx     : w_b_idx;
   assign w_lose_be    = c_b_wins ? a_mem_be    : b_mem_be;
   assign w_lose_wdata = c_b_wins ? a_mem_wdata : b_mem_wdata;
   assign w_win_wr     = c_b_wins ? w_b_wr      : w_a_wr;
   assign w_win_idx    = c_b_wins ? w_b_idx     : w_a_idx;
   assign w_win_be     = c_b_wins ? b_mem_be    : a_mem_be;
   assign w_win_wdata  = c_b_wins ? b_mem_wdata : a_mem_wdata;

   assign w_clr_lo = c_idx_w'(r_clr_idx);
   assign w_clr_hi = w_clr_lo + c_idx_w'(c_half);

   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[w_clr_lo] <= '0;
         r_mem[w_clr_hi] <= '0;
      end else begin
         for (int i = 0; i < c_be_w; i++) begin
            if (w_lose_wr && w_lose_be[i]) r_mem[w_lose_idx][i*8 +: 8] <= w_lose_wdata[i*8 +: 8];
            if (w_win_wr && w_win_be[i])   r_mem[w_win_idx][i*8 +: 8]  <= w_win_wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         r_clr_idx <= '0;
      end else if (r_state == ST_CLEAR) begin
         if (r_clr_idx == c_clr_w'(c_half - 1)) begin
            r_state   <= ST_RUN;
            r_clr_idx <= '0;
         end else begin
            r_clr_idx <= r_clr_idx + c_clr_w'(1);
         end
      end
   end

   bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_a_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (w_a_rd),
      .rd_data (w_a_rd_word),
      .rvalid  (a_mem_rvalid),
      .rdata   (a_mem_rdata)
   );

   bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_b_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (w_b_rd),
      .rd_data (w_b_rd_word),
      .rvalid  (b_mem_rvalid),
      .rdata   (b_mem_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_dualport_bram_sync.sv
`default_nettype none
// ============================================================================
// Module : tb_dualport_bram_sync
// Brief  : Directed bench; u_d0 = RD_LAT 2/RDW_OLD/B wins, u_d1 = RD_LAT 1/RDW_NEW/A wins
// Rev    : 1.0
// ============================================================================
module tb_dualport_bram_sync;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
   logic [3:0]  a_be = 0, b_be = 0;
   logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;

   logic        d0_a_ready, d0_a_rvalid, d0_b_ready, d0_b_rvalid, d0_init_done;
   logic [31:0] d0_a_rdata, d0_b_rdata;
   logic        d1_a_ready, d1_a_rvalid, d1_b_ready, d1_b_rvalid, d1_init_done;
   logic [31:0] d1_a_rdata, d1_b_rdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dualport_bram_sync #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(2), .RDW_MODE(RDW_OLD),
                        .WW_WINNER(PORT_B), .CLEAR_ON_RESET(1'b1)) u_d0 (
      .clk(clk), .rst_n(rst_n),
      .a_mem_req(a_req), .a_mem_we(a_we), .a_mem_be(a_be), .a_mem_addr(a_addr),
      .a_mem_wdata(a_wdata), .a_mem_ready(d0_a_ready), .a_mem_rvalid(d0_a_rvalid),
      .a_mem_rdata(d0_a_rdata),
      .b_mem_req(b_req), .b_mem_we(b_we), .b_mem_be(b_be), .b_mem_addr(b_addr),
      .b_mem_wdata(b_wdata), .b_mem_ready(d0_b_ready), .b_mem_rvalid(d0_b_rvalid),
      .b_mem_rdata(d0_b_rdata),
      .init_done(d0_init_done)
   );

   dualport_bram_sync #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(1), .RDW_MODE(RDW_NEW),
                        .WW_WINNER(PORT_A), .CLEAR_ON_RESET(1'b1)) u_d1 (
      .clk(clk), .rst_n(rst_n),
      .a_mem_req(a_req), .a_mem_we(a_we), .a_mem_be(a_be), .a_mem_addr(a_addr),
      .a_mem_wdata(a_wdata), .a_mem_ready(d1_a_ready), .a_mem_rvalid(d1_a_rvalid),
      .a_mem_rdata(d1_a_rdata),
      .b_mem_req(b_req), .b_mem_we(b_we), .b_mem_be(b_be), .b_mem_addr(b_addr),
      .b_mem_wdata(b_wdata), .b_mem_ready(d1_b_ready), .b_mem_rvalid(d1_b_rvalid),
      .b_mem_rdata(d1_b_rdata),
      .init_done(d1_init_done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      a_req = 0; b_req = 0; a_we = 0; b_we = 0;
   endtask

   task automatic write_word(input bit port_b, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
      if (port_b) begin b_req = 1; b_we = 1; b_addr = addr; b_wdata = data; b_be = be; end
      else        begin a_req = 1; a_we = 1; a_addr = addr; a_wdata = data; a_be = be; end
      tick;
      idle;
   endtask

   // tim = {d1 valid at N+1, d0 not yet valid at N+1, d0 valid at N+2, d1 dropped at N+2}
   task automatic read_word(input bit port_b, input logic [31:0] addr,
                            output logic [31:0] got0, output logic [31:0] got1,
                            output logic [3:0] tim);
      if (port_b) begin b_req = 1; b_we = 0; b_addr = addr; end
      else        begin a_req = 1; a_we = 0; a_addr = addr; end
      tick;
      idle;
      tick;
      tim[3] = port_b ? d1_b_rvalid : d1_a_rvalid;
      got1   = port_b ? d1_b_rdata  : d1_a_rdata;
      tim[2] = ~(port_b ? d0_b_rvalid : d0_a_rvalid);
      tick;
      tim[1] = port_b ? d0_b_rvalid : d0_a_rvalid;
      got0   = port_b ? d0_b_rdata  : d0_a_rdata;
      tim[0] = ~(port_b ? d1_b_rvalid : d1_a_rvalid);
   endtask

   task automatic test_reset;
      rst_n = 0;
      a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 0; b_addr = 0;
      tick; tick;
      n_checks++;
      if ({d0_a_ready, d0_b_ready, d1_a_ready, d1_b_ready} !== 4'b0000) begin
         n_errors++; $display("FAIL reset_ready: got %b exp 0000",
                              {d0_a_ready, d0_b_ready, d1_a_ready, d1_b_ready});
      end
      n_checks++;
      if ({d0_init_done, d1_init_done} !== 2'b00) begin
         n_errors++; $display("FAIL reset_init_done: got %b exp 00", {d0_init_done, d1_init_done});
      end
      n_checks++;
      if ({d0_a_rvalid, d0_b_rvalid, d1_a_rvalid, d1_b_rvalid} !== 4'b0000 ||
          {d0_a_rdata, d0_b_rdata, d1_a_rdata, d1_b_rdata} !== 128'h0) begin
         n_errors++; $display("FAIL reset_read_outputs: got valid %b data %h %h exp 0",
                              {d0_a_rvalid, d0_b_rvalid, d1_a_rvalid, d1_b_rvalid},
                              d0_a_rdata, d1_a_rdata);
      end
      rst_n = 1;
      for (int k = 1; k <= 8; k++) begin
         tick;
         n_checks++;
         if (d0_init_done !== (k == 8) || d1_init_done !== (k == 8)) begin
            n_errors++; $display("FAIL clear_init_done cycle %0d: got %b%b exp %0b",
                                 k, d0_init_done, d1_init_done, (k == 8));
         end
         n_checks++;
         if (d0_a_ready !== (k == 8) || d1_b_ready !== (k == 8)) begin
            n_errors++; $display("FAIL clear_ready cycle %0d: got %b%b exp %0b",
                                 k, d0_a_ready, d1_b_ready, (k == 8));
         end
         n_checks++;
         if ({d0_a_rvalid, d1_a_rvalid, d0_b_rvalid, d1_b_rvalid} !== 4'b0000) begin
            n_errors++; $display("FAIL clear_rvalid cycle %0d: got %b exp 0000", k,
                                 {d0_a_rvalid, d1_a_rvalid, d0_b_rvalid, d1_b_rvalid});
         end
      end
      idle;
   endtask

   task automatic test_clear_zero;
      logic [31:0] g0, g1;
      logic [3:0]  t;
      for (int i = 0; i < 16; i++) begin
         read_word(i[0], 32'(i * 4), g0, g1, t);
         n_checks++;
         if ({g0, g1, t} !== {64'h0, 4'hF}) begin
            n_errors++; $display("FAIL clear_zero word %0d: got %h %h tim %b exp 0 0 tim 1111",
                                 i, g0, g1, t);
         end
      end
   endtask

   task automatic test_byte_enable;
      logic [31:0] g0, g1;
      logic [3:0]  t;
      write_word(0, 32'h10, 32'hDEADBEEF, 4'hF);
      write_word(0, 32'h10, 32'h000000AA, 4'b0001);
      read_word(0, 32'h10, g0, g1, t);
      n_checks++;
      if ({g0, g1, t} !== {32'hDEADBEAA, 32'hDEADBEAA, 4'hF}) begin
         n_errors++; $display("FAIL byte_enable: got %h %h tim %b exp deadbeaa tim 1111", g0, g1, t);
      end
      read_word(1, 32'h50, g0, g1, t);
      n_checks++;
      if ({g0, g1, t} !== {32'hDEADBEAA, 32'hDEADBEAA, 4'hF}) begin
         n_errors++; $display("FAIL alias_read: got %h %h tim %b exp deadbeaa tim 1111", g0, g1, t);
      end
      write_word(1, 32'h10, 32'hFFFFFFFF, 4'b0000);
      read_word(0, 32'h10, g0, g1, t);
      n_checks++;
      if ({g0, g1} !== {32'hDEADBEAA, 32'hDEADBEAA}) begin
         n_errors++; $display("FAIL be_zero_noop: got %h %h exp deadbeaa", g0, g1);
      end
   endtask

   task automatic test_collision;
      logic [31:0] g0, g1;
      logic [3:0]  t;
      a_req = 1; a_we = 1; a_addr = 32'h8; a_wdata = 32'hAAAAAAAA; a_be = 4'b0011;
      b_req = 1; b_we = 1; b_addr = 32'h8; b_wdata = 32'hBBBBBBBB; b_be = 4'b0110;
      tick;
      idle;
      read_word(0, 32'h8, g0, g1, t);
      n_checks++;
      if (g0 !== 32'h00BBBBAA) begin
         n_errors++; $display("FAIL collision_b_wins: got %h exp 00bbbbaa", g0);
      end
      n_checks++;
      if (g1 !== 32'h00BBAAAA) begin
         n_errors++; $display("FAIL collision_a_wins: got %h exp 00bbaaaa", g1);
      end
   endtask

   task automatic test_pipeline;
      logic [31:0] w0 [3];
      logic [31:0] w1 [3];
      int i0, i1;
      write_word(1, 32'h0, 32'h00001111, 4'hF);
      write_word(1, 32'h4, 32'h22220000, 4'hF);
      w0[0] = 32'h00001111; w0[1] = 32'h22220000; w0[2] = 32'h00BBBBAA;
      w1[0] = 32'h00001111; w1[1] = 32'h22220000; w1[2] = 32'h00BBAAAA;
      a_req = 1; a_we = 0; a_addr = 32'h0;
      for (int k = 1; k <= 6; k++) begin
         tick;
         a_addr = 32'(4 * k);
         a_req  = (k < 3);
         n_checks++;
         if (d1_a_rvalid !== (k >= 2 && k <= 4)) begin
            n_errors++; $display("FAIL pipe_valid_lat1 edge %0d: got %b exp %0b",
                                 k, d1_a_rvalid, (k >= 2 && k <= 4));
         end
         n_checks++;
         if (d0_a_rvalid !== (k >= 3 && k <= 5)) begin
            n_errors++; $display("FAIL pipe_valid_lat2 edge %0d: got %b exp %0b",
                                 k, d0_a_rvalid, (k >= 3 && k <= 5));
         end
         if (k >= 2) begin
            i1 = (k - 2 > 2) ? 2 : k - 2;
            n_checks++;
            if (d1_a_rdata !== w1[i1]) begin
               n_errors++; $display("FAIL pipe_data_lat1 edge %0d: got %h exp %h", k, d1_a_rdata, w1[i1]);
            end
         end
         if (k >= 3) begin
            i0 = (k - 3 > 2) ? 2 : k - 3;
            n_checks++;
            if (d0_a_rdata !== w0[i0]) begin
               n_errors++; $display("FAIL pipe_data_lat2 edge %0d: got %h exp %h", k, d0_a_rdata, w0[i0]);
            end
         end
      end
      idle;
   endtask

   task automatic test_rdw;
      logic [31:0] g0, g1;
      logic [3:0]  t;
      write_word(0, 32'h20, 32'h11111111, 4'hF);
      a_req = 1; a_we = 0; a_addr = 32'h20;
      b_req = 1; b_we = 1; b_addr = 32'h20; b_wdata = 32'h22222222; b_be = 4'hF;
      tick;
      idle;
      tick;
      n_checks++;
      if (d1_a_rvalid !== 1'b1 || d1_a_rdata !== 32'h22222222) begin
         n_errors++; $display("FAIL rdw_new_a: got v=%b %h exp v=1 22222222", d1_a_rvalid, d1_a_rdata);
      end
      tick;
      n_checks++;
      if (d0_a_rvalid !== 1'b1 || d0_a_rdata !== 32'h11111111) begin
         n_errors++; $display("FAIL rdw_old_a: got v=%b %h exp v=1 11111111", d0_a_rvalid, d0_a_rdata);
      end
      read_word(0, 32'h20, g0, g1, t);
      n_checks++;
      if ({g0, g1} !== {32'h22222222, 32'h22222222}) begin
         n_errors++; $display("FAIL rdw_after_write: got %h %h exp 22222222", g0, g1);
      end
      write_word(0, 32'h24, 32'h33333333, 4'hF);
      b_req = 1; b_we = 0; b_addr = 32'h24;
      a_req = 1; a_we = 1; a_addr = 32'h24; a_wdata = 32'h44444444; a_be = 4'b0101;
      tick;
      idle;
      tick;
      n_checks++;
      if (d1_b_rvalid !== 1'b1 || d1_b_rdata !== 32'h33443344) begin
         n_errors++; $display("FAIL rdw_new_b_partial: got v=%b %h exp v=1 33443344", d1_b_rvalid, d1_b_rdata);
      end
      tick;
      n_checks++;
      if (d0_b_rvalid !== 1'b1 || d0_b_rdata !== 32'h33333333) begin
         n_errors++; $display("FAIL rdw_old_b: got v=%b %h exp v=1 33333333", d0_b_rvalid, d0_b_rdata);
      end
   endtask

   task automatic test_reset_mid_clear;
      logic [31:0] g0, g1;
      logic [3:0]  t;
      rst_n = 0;
      tick;
      rst_n = 1;
      for (int k = 1; k <= 4; k++) tick;
      n_checks++;
      if ({d0_init_done, d1_init_done} !== 2'b00) begin
         n_errors++; $display("FAIL midclear_busy: got %b%b exp 00", d0_init_done, d1_init_done);
      end
      rst_n = 0;
      tick;
      rst_n = 1;
      for (int k = 1; k <= 8; k++) begin
         tick;
         n_checks++;
         if (d0_init_done !== (k == 8) || d1_init_done !== (k == 8)) begin
            n_errors++; $display("FAIL midclear_restart cycle %0d: got %b%b exp %0b",
                                 k, d0_init_done, d1_init_done, (k == 8));
         end
      end
      read_word(0, 32'h10, g0, g1, t);
      n_checks++;
      if ({g0, g1, t} !== {64'h0, 4'hF}) begin
         n_errors++; $display("FAIL midclear_zeroed: got %h %h tim %b exp 0 0 tim 1111", g0, g1, t);
      end
   endtask

   task automatic test_reset_mid_read;
      write_word(0, 32'h28, 32'h5A5A5A5A, 4'hF);
      a_req = 1; a_we = 0; a_addr = 32'h28;
      tick;
      idle;
      rst_n = 0;
      #1;
      n_checks++;
      if ({d0_a_rvalid, d1_a_rvalid} !== 2'b00 || d0_a_rdata !== 32'h0 || d1_a_rdata !== 32'h0) begin
         n_errors++; $display("FAIL flush_async: got v=%b%b %h %h exp v=00 0 0",
                              d0_a_rvalid, d1_a_rvalid, d0_a_rdata, d1_a_rdata);
      end
      tick;
      rst_n = 1;
      for (int k = 1; k <= 10; k++) begin
         tick;
         n_checks++;
         if ({d0_a_rvalid, d1_a_rvalid} !== 2'b00) begin
            n_errors++; $display("FAIL flush_no_rvalid cycle %0d: got %b%b exp 00",
                                 k, d0_a_rvalid, d1_a_rvalid);
         end
      end
      n_checks++;
      if ({d0_init_done, d1_init_done} !== 2'b11) begin
         n_errors++; $display("FAIL flush_init_done: got %b%b exp 11", d0_init_done, d1_init_done);
      end
   endtask

   initial begin
      #2;
      test_reset;
      test_clear_zero;
      test_byte_enable;
      test_collision;
      test_pipeline;
      test_rdw;
      test_reset_mid_clear;
      test_reset_mid_read;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
